// File: rtl/int_request_ctrl.sv
// Interrupt front-end: edge-latched pending lines, mask + fixed priority, one-cycle Int pulse, RTI handshake.
// Optional macro INT_SYNC_STAGES_EN adds a two-flop synchronizer on every Irq line ahead of edge detect.
module int_request_ctrl #(
    parameter int N_IRQ  = 4,
    parameter int ID_W   = 3,
    parameter int LOST_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [N_IRQ-1:0]  Irq,
    input  logic [N_IRQ-1:0]  Mask,
    input  logic              Hold,
    input  logic              RtiDone,
    output logic              Int,
    output logic [ID_W-1:0]   IrqId,
    output logic              InService,
    output logic [N_IRQ-1:0]  Pending,
    output logic [LOST_W-1:0] LostCnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t              state_q;
    logic                int_q;
    logic [ID_W-1:0]     id_q;
    logic                insvc_q;

    logic [N_IRQ-1:0]    irq_eff;
    logic [N_IRQ-1:0]    prev_q;
    logic [N_IRQ-1:0]    rise;
    logic [N_IRQ-1:0]    pending_q;
    logic [N_IRQ-1:0]    pending_d;
    logic [N_IRQ-1:0]    cand;
    logic [N_IRQ-1:0]    clr;
    logic [ID_W-1:0]     winner;
    logic                dispatch;
    logic                lost_any;
    logic [LOST_W-1:0]   lost_q;
    logic [LOST_W-1:0]   lost_d;

`ifdef INT_SYNC_STAGES_EN
    logic [N_IRQ-1:0]    sync1_q;
    logic [N_IRQ-1:0]    sync2_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= Irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_eff = sync2_q;
`else
    assign irq_eff = Irq;
`endif

    assign rise = irq_eff & ~prev_q;
    assign cand = pending_q & Mask;

    // Descending scan so the lowest set index is the last one written and wins.
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    assign dispatch  = (state_q == IDLE) && (|cand) && !Hold;
    assign clr       = dispatch ? (N_IRQ'(1) << winner) : '0;
    assign pending_d = (pending_q & ~clr) | rise;

    // A rise on a line already pending is lost unless that line is being dispatched this cycle.
    assign lost_any  = |(rise & pending_q & ~clr);
    assign lost_d    = (lost_any && (lost_q != {LOST_W{1'b1}})) ? lost_q + LOST_W'(1) : lost_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            prev_q    <= '0;
            pending_q <= '0;
            lost_q    <= '0;
        end else begin
            prev_q    <= irq_eff;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            id_q    <= '0;
            insvc_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dispatch) begin
                        int_q   <= 1'b1;
                        id_q    <= winner;
                        insvc_q <= 1'b1;
                        state_q <= SERVICE;
                    end else begin
                        int_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    int_q <= 1'b0;
                    if (RtiDone) begin
                        insvc_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    int_q   <= 1'b0;
                    insvc_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Int       = int_q;
    assign IrqId     = id_q;
    assign InService = insvc_q;
    assign Pending   = pending_q;
    assign LostCnt   = lost_q;

endmodule

// File: tb/tb_int_request_ctrl.sv
// Bench for int_request_ctrl: directed scenarios with fixed expectations plus randomized traffic
// compared every cycle against a behavioural model.
module tb_int_request_ctrl;

    localparam int N_IRQ  = 4;
    localparam int ID_W   = 3;
    localparam int LOST_W = 8;
    localparam int LOST_MAX = (1 << LOST_W) - 1;

    logic              Clk = 1'b0;
    logic              Rst;
    logic [N_IRQ-1:0]  Irq;
    logic [N_IRQ-1:0]  Mask;
    logic              Hold;
    logic              RtiDone;
    logic              Int;
    logic [ID_W-1:0]   IrqId;
    logic              InService;
    logic [N_IRQ-1:0]  Pending;
    logic [LOST_W-1:0] LostCnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [N_IRQ-1:0] m_prev, m_pend, m_s1, m_s2;
    bit               m_busy, m_int;
    int               m_id, m_lost;

    int_request_ctrl #(.N_IRQ(N_IRQ), .ID_W(ID_W), .LOST_W(LOST_W)) dut (
        .Clk(Clk), .Rst(Rst), .Irq(Irq), .Mask(Mask), .Hold(Hold), .RtiDone(RtiDone),
        .Int(Int), .IrqId(IrqId), .InService(InService), .Pending(Pending), .LostCnt(LostCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [N_IRQ-1:0] eff, rise, clr;
        int  win;
        bit  lost;
        if (!Rst) begin
            m_prev = '0; m_pend = '0; m_s1 = '0; m_s2 = '0;
            m_busy = 0; m_int = 0; m_id = 0; m_lost = 0;
            return;
        end
`ifdef INT_SYNC_STAGES_EN
        eff  = m_s2;
        m_s2 = m_s1;
        m_s1 = Irq;
`else
        eff  = Irq;
`endif
        rise = '0;
        for (int i = 0; i < N_IRQ; i++) rise[i] = eff[i] && !m_prev[i];
        clr = '0;
        win = -1;
        if (!m_busy) begin
            for (int i = 0; i < N_IRQ; i++)
                if (win < 0 && m_pend[i] && Mask[i]) win = i;
            if (win >= 0 && !Hold) begin
                clr[win] = 1'b1;
                m_int  = 1;
                m_id   = win;
                m_busy = 1;
            end else begin
                m_int = 0;
            end
        end else begin
            m_int = 0;
            if (RtiDone) m_busy = 0;
        end
        lost = 0;
        for (int i = 0; i < N_IRQ; i++)
            if (rise[i] && m_pend[i] && !clr[i]) lost = 1;
        if (lost && m_lost < LOST_MAX) m_lost++;
        m_pend = (m_pend & ~clr) | rise;
        m_prev = eff;
    endtask

    // One clock: model follows the edge, then all outputs are compared mid-cycle.
    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check("model_int",   32'(Int),       32'(m_int));
        check("model_id",    32'(IrqId),     32'(m_id));
        check("model_insvc", 32'(InService), 32'(m_busy));
        check("model_pend",  32'(Pending),   32'(m_pend));
        check("model_lost",  32'(LostCnt),   32'(m_lost));
    endtask

    // Extra cycles so directed timing is the same with the input synchronizer present.
    task automatic settle();
`ifdef INT_SYNC_STAGES_EN
        tick();
        tick();
`endif
    endtask

    task automatic do_reset();
        Rst = 1'b0; Irq = '0; Hold = 1'b0; RtiDone = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
    endtask

    task automatic rti();
        RtiDone = 1'b1;
        tick();
        RtiDone = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; Irq = '0; Mask = '0; Hold = 1'b0; RtiDone = 1'b0;
        m_prev = '0; m_pend = '0; m_s1 = '0; m_s2 = '0;
        m_busy = 0; m_int = 0; m_id = 0; m_lost = 0;
        do_reset();
        check("rst_int",   32'(Int),       32'd0);
        check("rst_id",    32'(IrqId),     32'd0);
        check("rst_insvc", 32'(InService), 32'd0);
        check("rst_pend",  32'(Pending),   32'd0);
        check("rst_lost",  32'(LostCnt),   32'd0);

        // Single request on line 2
        Mask = 4'b1111;
        tick();
        Irq = 4'b0100;
        settle();
        tick();
        check("t1_pend_set", 32'(Pending), 32'h4);
        check("t1_int_low",  32'(Int),     32'd0);
        tick();
        check("t1_int",      32'(Int),       32'd1);
        check("t1_id",       32'(IrqId),     32'd2);
        check("t1_insvc",    32'(InService), 32'd1);
        check("t1_pend_clr", 32'(Pending),   32'h0);
        tick();
        check("t1_pulse1",   32'(Int),       32'd0);
        check("t1_insvc_hold", 32'(InService), 32'd1);
        tick();
        rti();
        check("t1_rti",      32'(InService), 32'd0);
        Irq = 4'b0000;
        tick();
        settle();

        // Simultaneous lines 3 and 1
        Irq = 4'b1010;
        settle();
        tick();
        tick();
        check("t2_int1", 32'(Int),   32'd1);
        check("t2_id1",  32'(IrqId), 32'd1);
        tick();
        rti();
        check("t2_gap",  32'(Int),   32'd0);
        tick();
        check("t2_int2", 32'(Int),   32'd1);
        check("t2_id2",  32'(IrqId), 32'd3);
        rti();
        Irq = 4'b0000;
        tick();
        settle();

        // Masked latch, then unmask
        Mask = 4'b0000;
        Irq  = 4'b0001;
        settle();
        tick();
        check("t3_pend", 32'(Pending), 32'h1);
        tick();
        check("t3_masked", 32'(Int), 32'd0);
        Mask = 4'b0001;
        tick();
        check("t3_int", 32'(Int),   32'd1);
        check("t3_id",  32'(IrqId), 32'd0);

        // Lost edges while servicing line 0
        do_reset();
        Mask = 4'b1111;
        Irq  = 4'b0001;
        settle();
        tick();
        tick();
        check("t4_svc0", 32'(IrqId), 32'd0);
        for (int k = 0; k < 3; k++) begin
            Irq = 4'b0011;
            tick();
            Irq = 4'b0001;
            tick();
        end
        settle();
        check("t4_lost2", 32'(LostCnt), 32'd2);
        check("t4_pend1", 32'(Pending), 32'h2);

        // Saturation of the lost counter
        do_reset();
        Mask = 4'b0000;
        for (int k = 0; k < 300; k++) begin
            Irq = 4'b0001;
            tick();
            Irq = 4'b0000;
            tick();
        end
        settle();
        check("t4_sat", 32'(LostCnt), 32'(LOST_MAX));

        // Hold stalls dispatch; reset mid-service
        do_reset();
        Mask = 4'b1111;
        Hold = 1'b1;
        Irq  = 4'b0010;
        settle();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_hold", 32'(Int), 32'd0);
        end
        Hold = 1'b0;
        tick();
        check("t5_int", 32'(Int),   32'd1);
        check("t5_id",  32'(IrqId), 32'd1);
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        check("t5_rst_int",   32'(Int),       32'd0);
        check("t5_rst_id",    32'(IrqId),     32'd0);
        check("t5_rst_insvc", 32'(InService), 32'd0);
        check("t5_rst_pend",  32'(Pending),   32'd0);
        check("t5_rst_lost",  32'(LostCnt),   32'd0);

`ifdef INT_SYNC_STAGES_EN
        // Synchronizer latency: Int four edges after Irq is first sampled high
        do_reset();
        Mask = 4'b1111;
        Irq  = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_early", 32'(Int), 32'd0);
        end
        tick();
        check("t6_int", 32'(Int), 32'd1);
        rti();
`endif

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            Irq     = N_IRQ'($urandom_range(0, (1 << N_IRQ) - 1));
            if ($urandom_range(0, 7) == 0)
                Mask = N_IRQ'($urandom_range(0, (1 << N_IRQ) - 1));
            Hold    = ($urandom_range(0, 3) == 0);
            RtiDone = ($urandom_range(0, 4) == 0);
            Rst     = ($urandom_range(0, 199) != 0);
            tick();
        end
        Rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_request_ctrl.md
Name: int_request_ctrl

Overview:
- Interrupt front-end that sits directly upstream of the processor's single `Int` input.
- Detects rising edges on several external interrupt lines, latches them as pending, applies a mask and fixed priority, and issues a one-cycle `Int` pulse with the winning line ID.
- Blocks further dispatch until the processor signals RTI retirement.
- Keeps a saturating count of edges lost because their line was already pending.

Parameters:
- N_IRQ, 4, number of external interrupt lines (2..8).
- ID_W, 3, width of IrqId; must satisfy 2^ID_W >= N_IRQ.
- LOST_W, 8, width of the lost-edge counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  reset, synchronous, active-low.
- Irq  in  N_IRQ  external request lines, level signals; a 0->1 transition is a request.
- Mask  in  N_IRQ  1 = line enabled for dispatch; masking never blocks latching.
- Hold  in  1  processor stall; while 1, no new dispatch starts.
- RtiDone  in  1  one-cycle pulse from the processor when RTI retires.
- Int  out  1  interrupt pulse to the processor, registered.
- IrqId  out  ID_W  ID of the line in service, registered.
- InService  out  1  high from the Int pulse until RtiDone.
- Pending  out  N_IRQ  current pending register.
- LostCnt  out  LOST_W  saturating lost-edge count.

Behaviour:
- Reset: Rst=0 at a rising edge clears everything: Int=0, IrqId=0, InService=0, Pending=0, LostCnt=0, edge-history register=0, FSM=IDLE.
  - Reset mid-service drops the in-flight request with no pulse.
- Edge detect:
  - prev <= Irq_eff every cycle.
  - edge = Irq_eff & ~prev.
  - Irq_eff is Irq directly, or the synchronized copy (see Optional Feature).
- Pending update per bit i, evaluated each edge:
  - Pending[i] <= (Pending[i] & ~clr[i]) | edge[i].
  - clr[i] = dispatch of line i this cycle.
  - Set wins over clear when both occur in the same cycle.
- Lost edges: when edge[i]=1 and Pending[i]=1 and clr[i]=0, LostCnt increments by 1.
  - Several simultaneous lost edges count as +1 per cycle.
  - LostCnt saturates at 2^LOST_W-1 and never wraps.
- Candidate: cand = Pending & Mask. Winner = lowest set index (line 0 highest priority).
- FSM:
  - IDLE:
    - If cand != 0 and Hold=0: register Int<=1, IrqId<=winner, InService<=1, clear Pending[winner], go to SERVICE.
    - Otherwise Int<=0.
  - SERVICE:
    - Int<=0 (the pulse is exactly one cycle).
    - Edges keep latching.
    - On RtiDone=1: InService<=0, go to IDLE.
    - IrqId holds its value.
  - RtiDone in IDLE is ignored.
  - Hold is ignored once in SERVICE.
- Re-dispatch: the earliest is the cycle after returning to IDLE, so back-to-back interrupts are separated by at least one Int-low cycle.
- Latency without the sync option:
  - Irq first sampled high at edge E0 sets Pending after E0.
  - Int is high during the cycle after E1 (two edges from sampling), provided Mask=1, Hold=0, IDLE.
- Mask change: a masked pending line is dispatched the first cycle after its Mask bit rises, subject to priority and Hold.
- Level held high: does not re-request; only a new 0->1 transition does.

Optional Feature:
- Macro: INT_SYNC_STAGES_EN.
- Defined: Irq passes through a two-flop synchronizer per line before edge detect.
  - Irq_eff lags Irq by 2 cycles, so Int-from-sampling latency becomes 4 edges.
  - Synchronizer flops reset to 0.
- Undefined: Irq_eff = Irq; Irq is assumed already synchronous to Clk.

Test Plan (without INT_SYNC_STAGES_EN unless noted):
1. Reset, Mask=4'b1111, Irq[2] rises at edge 5 -> Pending=4'b0100 after edge 5; Int=1, IrqId=2, InService=1 after edge 6 for exactly one cycle; Pending=0; RtiDone pulse at edge 10 -> InService=0 after edge 10.
2. Irq[3] and Irq[1] rise on the same edge, Mask=4'b1111 -> first dispatch IrqId=1; after RtiDone, next dispatch IrqId=3, with at least one Int-low cycle between the two.
3. Mask=4'b0000, Irq[0] rises -> Pending=4'b0001, Int stays 0; set Mask[0]=1 -> Int=1, IrqId=0 on the following cycle.
4. Irq[1] toggled 0->1 three times while Pending[1]=1 and in SERVICE on line 0 -> LostCnt=2 (first edge after dispatch clear counts as latch, not lost); preload 255 edges -> LostCnt stays 255.
5. Hold=1 with Pending=4'b0010 for 5 cycles -> Int=0 throughout; Hold falls -> Int pulses with IrqId=1 next cycle. Then Rst=0 while in SERVICE -> all outputs 0 after that edge.
6. INT_SYNC_STAGES_EN defined: Irq[0] rises before edge 5 -> Int=1 after edge 8 (vs. after edge 6 without the macro).
